axi4lite_reg_slave: RTL

- AXI4-Lite responder (slave) exposing a bank of NUM_REGS 32-bit read/write control registers plus one read-only status word.
- Counterpart to the team's AXI4-Lite master: it answers that master's single-beat reads and writes.
- Write and read channels are handled by independent state machines.
- Register contents drive fabric logic directly; the status word is sampled from fabric.

---
 rtl/axi4lite_reg_slave.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi4lite_reg_slave.sv
// -----------------------------------------------------------------------------
// axi4lite_reg_slave
//   AXI4-Lite responder for a bank of NUM_REGS read/write control registers
//   plus one read-only status word. It serves single-beat reads and writes.
//   The write and read channels run independent state machines.
//
//   Word map (byte address >> 2):
//     0 .. NUM_REGS-1 : control registers (RW)
//     NUM_REGS        : status word, sampled from status_in when AR is accepted
//     anything else   : out of range. Writes are dropped; reads return 0.
//                       Both answer with SLVERR.
//
// Ports
//   s_axi_aclk, s_axi_areset : clock, asynchronous active-high reset
//   S_AXI_AW* / S_AXI_W*     : write address / write data + strobes
//   S_AXI_B*                 : write response
//   S_AXI_AR* / S_AXI_R*     : read address / read data + response
//   reg_bank_out             : control registers, reg i at [32i+31:32i]
//   reg_wr_pulse             : one-cycle strobe per register on a successful write
//   status_in                : read-only status word from fabric
//
// state  | meaning
// -------+---------------------------------------------------------------
// W_IDLE | collecting AW and W (either order); commit once both are held
// W_RESP | write committed, BVALID/BRESP held until BREADY
// R_IDLE | ARREADY high, waiting for a read address
// R_DATA | RVALID/RDATA/RRESP held until RREADY
// -----------------------------------------------------------------------------
module axi4lite_reg_slave #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS           = 8
) (
  input  logic                                   s_axi_aclk,
  input  logic                                   s_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_bank_out,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          status_in
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } wstate_e;
  typedef enum logic { R_IDLE, R_DATA } rstate_e;

  wstate_e                     wstate_q;
  rstate_e                     rstate_q;
  logic [NUM_REGS-1:0][DW-1:0] regs_q;
  logic [NUM_REGS-1:0]         wr_pulse_q;

  logic          aw_held_q, w_held_q;
  logic [AW-1:0] awaddr_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  logic          awready_q, wready_q, bvalid_q;
  logic [1:0]    bresp_q;

  logic          arready_q, rvalid_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    rresp_q;

  // Write-side view of this edge: a buffered beat or one handshaking now.
  logic          aw_hs, w_hs, aw_full, w_full, wr_commit;
  logic [AW-1:0] awaddr_d, wr_word;
  logic [DW-1:0] wdata_d;
  logic [SW-1:0] wstrb_d;
  logic          wr_is_reg;

  always_comb begin
    aw_hs     = S_AXI_AWVALID && awready_q;
    w_hs      = S_AXI_WVALID && wready_q;
    aw_full   = aw_held_q || aw_hs;
    w_full    = w_held_q || w_hs;
    awaddr_d  = aw_hs ? S_AXI_AWADDR : awaddr_q;
    wdata_d   = w_hs ? S_AXI_WDATA : wdata_q;
    wstrb_d   = w_hs ? S_AXI_WSTRB : wstrb_q;
    wr_commit = (wstate_q == W_IDLE) && aw_full && w_full;
    // The word index is compared on the whole word address. Any set bit above
    // the index field therefore falls out of range, and addr[1:0] is dropped.
    wr_word   = awaddr_d >> 2;
    wr_is_reg = wr_word < AW'(NUM_REGS);
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      wstate_q   <= W_IDLE;
      regs_q     <= '0;
      wr_pulse_q <= '0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_pulse_q <= '0;
      case (wstate_q)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held_q <= 1'b1;
            awaddr_q  <= S_AXI_AWADDR;
          end
          if (w_hs) begin
            w_held_q <= 1'b1;
            wdata_q  <= S_AXI_WDATA;
            wstrb_q  <= S_AXI_WSTRB;
          end
          if (wr_commit) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            wstate_q  <= W_RESP;
            bresp_q   <= wr_is_reg ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
              if (wr_word == AW'(i)) begin
                // An all-zero strobe still counts as a write and still pulses.
                wr_pulse_q[i] <= 1'b1;
                for (int b = 0; b < SW; b++) begin
                  if (wstrb_d[b]) regs_q[i][8*b +: 8] <= wdata_d[8*b +: 8];
                end
              end
            end
          end else begin
            awready_q <= !aw_full;
            wready_q  <= !w_full;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Read mux. regs_q is sampled before any commit on the same edge, so a read
  // that collides with a write returns the pre-write value.
  logic [AW-1:0] rd_word;
  logic [DW-1:0] rd_data_c;
  logic [1:0]    rd_resp_c;

  always_comb begin
    rd_word   = S_AXI_ARADDR >> 2;
    rd_data_c = '0;
    rd_resp_c = RESP_SLVERR;
    if (rd_word < AW'(NUM_REGS)) begin
      rd_resp_c = RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rd_word == AW'(i)) rd_data_c = regs_q[i];
      end
    end else if (rd_word == AW'(NUM_REGS)) begin
      rd_resp_c = RESP_OKAY;
      rd_data_c = status_in;
    end
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (S_AXI_ARVALID && arready_q) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_data_c;
            rresp_q   <= rd_resp_c;
            rstate_q  <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end
        end
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign reg_bank_out  = regs_q;
  assign reg_wr_pulse  = wr_pulse_q;

endmodule
